// File: rtl/pe_eject_pkg.sv
// Shared constants, flit-type encodings and helpers for the PE ejection buffer.
package pe_eject_pkg;

    localparam int unsigned VCHW        = 0;             // msb index of a VC id
    localparam int unsigned DATAW       = 31;            // msb index of a flit
    localparam int unsigned VCH_BITS    = VCHW + 1;
    localparam int unsigned DATA_BITS   = DATAW + 1;
    localparam int unsigned NUM_VCH     = 1 << VCH_BITS;
    localparam int unsigned PE_EJ_DEPTH = 4;
    localparam int unsigned TYPE_MSB    = 31;
    localparam int unsigned TYPE_LSB    = 30;

    typedef enum logic [1:0] {
        FLIT_BODY     = 2'b00,
        FLIT_HEAD     = 2'b01,
        FLIT_TAIL     = 2'b10,
        FLIT_HEADTAIL = 2'b11
    } flit_type_e;

    typedef enum logic {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_e;

    function automatic flit_type_e flit_type(input logic [DATA_BITS-1:0] flit);
        return flit_type_e'(flit[TYPE_MSB:TYPE_LSB]);
    endfunction

    function automatic logic opens_pkt(input logic [DATA_BITS-1:0] flit);
        return (flit_type(flit) == FLIT_HEAD) || (flit_type(flit) == FLIT_HEADTAIL);
    endfunction

    function automatic logic closes_pkt(input logic [DATA_BITS-1:0] flit);
        return (flit_type(flit) == FLIT_TAIL) || (flit_type(flit) == FLIT_HEADTAIL);
    endfunction

endpackage

// File: rtl/pe_eject_vcfifo.sv
// Single-VC synchronous FIFO; a push while full is taken only if a pop happens in the same cycle.
module pe_eject_vcfifo
    import pe_eject_pkg::*;
#(
    parameter int unsigned DEPTH = PE_EJ_DEPTH,
    parameter int unsigned W     = DATA_BITS
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] rdata
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (!rst_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pe_eject.sv
// PE-side ejection buffer: per-VC FIFOs, whole-packet round-robin delivery, credit return.
// Optional macro PE_EJECT_STATS_EN adds opkt_cnt, a wrapping count of forwarded packet tails.
module pe_eject
    import pe_eject_pkg::*;
#(
    parameter int unsigned DEPTH = PE_EJ_DEPTH,
    parameter int unsigned NVCH  = NUM_VCH
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic [DATA_BITS-1:0] idata,
    input  logic                 ivalid,
    input  logic [VCH_BITS-1:0]  ivch,
    input  logic                 iready,
    output logic [DATA_BITS-1:0] odata,
    output logic                 ovalid,
    output logic                 ocredit,
    output logic [VCH_BITS-1:0]  ocredit_vch,
    output logic                 oerr
`ifdef PE_EJECT_STATS_EN
    ,
    output logic [15:0]          opkt_cnt
`endif
);

    arb_state_e           state;
    logic [VCH_BITS-1:0]  lock_vc;
    logic [VCH_BITS-1:0]  rr;

    logic [NVCH-1:0]      fifo_full;
    logic [NVCH-1:0]      fifo_empty;
    logic [NVCH-1:0]      fifo_push;
    logic [NVCH-1:0]      fifo_pop;
    logic [DATA_BITS-1:0] fifo_head [NVCH];

    logic                 pop_en;
    logic [VCH_BITS-1:0]  pop_vc;
    logic [VCH_BITS-1:0]  cand;
    logic [DATA_BITS-1:0] pop_flit;
    logic                 push_drop;
    logic                 proto_err;

    // One FIFO per virtual channel
    for (genvar v = 0; v < NVCH; v++) begin : g_vc
        assign fifo_push[v] = ivalid && (ivch == VCH_BITS'(v));
        assign fifo_pop[v]  = pop_en && (pop_vc == VCH_BITS'(v));

        pe_eject_vcfifo #(
            .DEPTH (DEPTH),
            .W     (DATA_BITS)
        ) u_fifo (
            .clk   (clk),
            .rst_  (rst_),
            .push  (fifo_push[v]),
            .pop   (fifo_pop[v]),
            .wdata (idata),
            .full  (fifo_full[v]),
            .empty (fifo_empty[v]),
            .rdata (fifo_head[v])
        );
    end

    // Pop selection: locked VC only, otherwise first non-empty VC from rr
    always_comb begin
        pop_en = 1'b0;
        pop_vc = rr;
        cand   = '0;
        if (state == ARB_LOCKED) begin
            pop_vc = lock_vc;
            pop_en = iready && !fifo_empty[lock_vc];
        end else if (iready) begin
            for (int unsigned k = 0; k < NVCH; k++) begin
                cand = rr + VCH_BITS'(k);
                if (!pop_en && !fifo_empty[cand]) begin
                    pop_en = 1'b1;
                    pop_vc = cand;
                end
            end
        end
    end

    assign pop_flit  = fifo_head[pop_vc];
    assign push_drop = ivalid && fifo_full[ivch] && !fifo_pop[ivch];
    assign proto_err = pop_en && (state == ARB_UNLOCKED) && !opens_pkt(pop_flit);

    // Lock FSM, round-robin pointer, registered outputs and error flag
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state       <= ARB_UNLOCKED;
            lock_vc     <= '0;
            rr          <= '0;
            odata       <= '0;
            ovalid      <= 1'b0;
            ocredit     <= 1'b0;
            ocredit_vch <= '0;
            oerr        <= 1'b0;
        end else begin
            ovalid  <= pop_en;
            ocredit <= pop_en;
            if (pop_en) begin
                odata       <= pop_flit;
                ocredit_vch <= pop_vc;
                rr          <= pop_vc + VCH_BITS'(1);
            end
            if (push_drop || proto_err) begin
                oerr <= 1'b1;
            end
            case (state)
                ARB_UNLOCKED: begin
                    if (pop_en && (flit_type(pop_flit) == FLIT_HEAD)) begin
                        state   <= ARB_LOCKED;
                        lock_vc <= pop_vc;
                    end
                end
                ARB_LOCKED: begin
                    if (pop_en && closes_pkt(pop_flit)) begin
                        state <= ARB_UNLOCKED;
                    end
                end
                default: state <= ARB_UNLOCKED;
            endcase
        end
    end

`ifdef PE_EJECT_STATS_EN
    // Forwarded-packet counter, advanced when a closing flit is popped
    always_ff @(posedge clk) begin
        if (!rst_) begin
            opkt_cnt <= '0;
        end else if (pop_en && closes_pkt(pop_flit)) begin
            opkt_cnt <= opkt_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_eject.sv
// Directed self-checking bench for pe_eject.
module tb_pe_eject;
    import pe_eject_pkg::*;

    logic                 clk;
    logic                 rst_;
    logic [DATA_BITS-1:0] idata;
    logic                 ivalid;
    logic [VCH_BITS-1:0]  ivch;
    logic                 iready;
    logic [DATA_BITS-1:0] odata;
    logic                 ovalid;
    logic                 ocredit;
    logic [VCH_BITS-1:0]  ocredit_vch;
    logic                 oerr;
`ifdef PE_EJECT_STATS_EN
    logic [15:0]          opkt_cnt;
`endif

    int total = 0;
    int bad   = 0;

    pe_eject dut (
        .clk         (clk),
        .rst_        (rst_),
        .idata       (idata),
        .ivalid      (ivalid),
        .ivch        (ivch),
        .iready      (iready),
        .odata       (odata),
        .ovalid      (ovalid),
        .ocredit     (ocredit),
        .ocredit_vch (ocredit_vch),
        .oerr        (oerr)
`ifdef PE_EJECT_STATS_EN
        ,
        .opkt_cnt    (opkt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_BITS-1:0] mk(input flit_type_e t, input int payload);
        return {t, 30'(payload)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_   = 1'b0;
        ivalid = 1'b0;
        iready = 1'b0;
        ivch   = '0;
        idata  = '0;
        step();
        rst_ = 1'b1;
    endtask

    task automatic test_reset();
        rst_ = 1'b1;
        apply_reset();
        total++; if (odata !== '0) begin bad++; $display("FAIL reset_odata got=%h exp=0", odata); end
        total++; if (ovalid !== 1'b0) begin bad++; $display("FAIL reset_ovalid got=%b exp=0", ovalid); end
        total++; if (ocredit !== 1'b0) begin bad++; $display("FAIL reset_ocredit got=%b exp=0", ocredit); end
        total++; if (ocredit_vch !== '0) begin bad++; $display("FAIL reset_ocredit_vch got=%h exp=0", ocredit_vch); end
        total++; if (oerr !== 1'b0) begin bad++; $display("FAIL reset_oerr got=%b exp=0", oerr); end
    endtask

    task automatic test_single();
        logic [DATA_BITS-1:0] f;
        f      = mk(FLIT_HEADTAIL, 'h1234);
        iready = 1'b1;
        ivalid = 1'b1; ivch = 1'b0; idata = f;
        step();
        ivalid = 1'b0;
        total++; if (ovalid !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", ovalid); end
        step();
        total++; if (ovalid !== 1'b1) begin bad++; $display("FAIL single_ovalid got=%b exp=1", ovalid); end
        total++; if (odata !== f) begin bad++; $display("FAIL single_odata got=%h exp=%h", odata, f); end
        total++; if (ocredit !== 1'b1 || ocredit_vch !== 1'b0) begin
            bad++; $display("FAIL single_credit got=%b/%h exp=1/0", ocredit, ocredit_vch);
        end
        step();
        total++; if (ovalid !== 1'b0 || ocredit !== 1'b0) begin
            bad++; $display("FAIL single_after got=%b/%b exp=0/0", ovalid, ocredit);
        end
    endtask

    task automatic test_interleave();
        logic [DATA_BITS-1:0] exp_d [8];
        logic [VCH_BITS-1:0]  exp_v [8];
        flit_type_e t;
        int n = 0;
        int c0 = 0;
        int c1 = 0;
        for (int k = 0; k < 4; k++) begin
            t = (k == 0) ? FLIT_HEAD : ((k == 3) ? FLIT_TAIL : FLIT_BODY);
            exp_d[k]     = mk(t, 16 + k);
            exp_v[k]     = 1'b1;
            exp_d[4 + k] = mk(t, k);
            exp_v[4 + k] = 1'b0;
        end
        iready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc < 8) begin
                ivalid = 1'b1;
                ivch   = (cyc % 2 == 0) ? 1'b1 : 1'b0;
                idata  = (cyc % 2 == 0) ? exp_d[cyc / 2] : exp_d[4 + cyc / 2];
            end else begin
                ivalid = 1'b0;
            end
            step();
            if (ocredit) begin
                if (ocredit_vch == 1'b0) c0++; else c1++;
            end
            if (ovalid) begin
                if (n < 8) begin
                    total++;
                    if (odata !== exp_d[n] || ocredit !== 1'b1 || ocredit_vch !== exp_v[n]) begin
                        bad++;
                        $display("FAIL interleave_flit%0d got=%h/%b/%h exp=%h/1/%h",
                                 n, odata, ocredit, ocredit_vch, exp_d[n], exp_v[n]);
                    end
                end
                n++;
            end
        end
        ivalid = 1'b0;
        total++; if (n !== 8) begin bad++; $display("FAIL interleave_count got=%0d exp=8", n); end
        total++; if (c0 !== 4 || c1 !== 4) begin
            bad++; $display("FAIL interleave_credits got=%0d/%0d exp=4/4", c0, c1);
        end
    endtask

    task automatic test_stall();
        logic [DATA_BITS-1:0] f [3];
        int bad_cyc = 0;
        f[0] = mk(FLIT_HEAD, 'h51); f[1] = mk(FLIT_BODY, 'h52); f[2] = mk(FLIT_TAIL, 'h53);
        iready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ivalid = 1'b1; ivch = 1'b0; idata = f[i];
            step();
            if (ovalid || ocredit) bad_cyc++;
        end
        ivalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ovalid || ocredit) bad_cyc++;
        end
        total++; if (bad_cyc !== 0) begin bad++; $display("FAIL stall_quiet got=%0d active cycles exp=0", bad_cyc); end
        iready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (ovalid !== 1'b1 || odata !== f[i] || ocredit !== 1'b1) begin
                bad++; $display("FAIL stall_out%0d got=%b/%h/%b exp=1/%h/1", i, ovalid, odata, ocredit, f[i]);
            end
        end
        step();
        total++; if (ovalid !== 1'b0) begin bad++; $display("FAIL stall_end got=%b exp=0", ovalid); end
    endtask

    task automatic test_full_pop();
        logic [DATA_BITS-1:0] f [5];
        int n = 0;
        f[0] = mk(FLIT_HEAD, 'h61); f[1] = mk(FLIT_BODY, 'h62); f[2] = mk(FLIT_BODY, 'h63);
        f[3] = mk(FLIT_BODY, 'h64); f[4] = mk(FLIT_TAIL, 'h65);
        iready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ivalid = 1'b1; ivch = 1'b0; idata = f[i];
            step();
        end
        iready = 1'b1; ivalid = 1'b1; idata = f[4];
        step();
        ivalid = 1'b0;
        total++; if (oerr !== 1'b0) begin bad++; $display("FAIL fullpop_oerr got=%b exp=0", oerr); end
        total++; if (ovalid !== 1'b1 || odata !== f[0]) begin
            bad++; $display("FAIL fullpop_first got=%b/%h exp=1/%h", ovalid, odata, f[0]);
        end
        n = 1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            step();
            if (ovalid) begin
                if (n < 5) begin
                    total++;
                    if (odata !== f[n]) begin bad++; $display("FAIL fullpop_flit%0d got=%h exp=%h", n, odata, f[n]); end
                end
                n++;
            end
        end
        total++; if (n !== 5) begin bad++; $display("FAIL fullpop_count got=%0d exp=5", n); end
        total++; if (oerr !== 1'b0) begin bad++; $display("FAIL fullpop_oerr_end got=%b exp=0", oerr); end
    endtask

    task automatic test_overflow();
        logic [DATA_BITS-1:0] f [5];
        int n = 0;
        f[0] = mk(FLIT_HEAD, 'h71); f[1] = mk(FLIT_BODY, 'h72); f[2] = mk(FLIT_BODY, 'h73);
        f[3] = mk(FLIT_TAIL, 'h74); f[4] = mk(FLIT_HEADTAIL, 'h75);
        iready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ivalid = 1'b1; ivch = 1'b0; idata = f[i];
            step();
            if (i == 3) begin
                total++; if (oerr !== 1'b0) begin bad++; $display("FAIL overflow_pre got=%b exp=0", oerr); end
            end
        end
        ivalid = 1'b0;
        total++; if (oerr !== 1'b1) begin bad++; $display("FAIL overflow_oerr got=%b exp=1", oerr); end
        iready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            step();
            if (ovalid) begin
                if (n < 4) begin
                    total++;
                    if (odata !== f[n]) begin bad++; $display("FAIL overflow_flit%0d got=%h exp=%h", n, odata, f[n]); end
                end
                n++;
            end
        end
        total++; if (n !== 4) begin bad++; $display("FAIL overflow_count got=%0d exp=4", n); end
        total++; if (oerr !== 1'b1) begin bad++; $display("FAIL overflow_sticky got=%b exp=1", oerr); end
        apply_reset();
        total++; if (oerr !== 1'b0) begin bad++; $display("FAIL overflow_clear got=%b exp=0", oerr); end
    endtask

    task automatic test_proto_err();
        logic [DATA_BITS-1:0] f;
        f      = mk(FLIT_BODY, 'h81);
        iready = 1'b1;
        ivalid = 1'b1; ivch = 1'b1; idata = f;
        step();
        ivalid = 1'b0;
        step();
        total++; if (ovalid !== 1'b1 || odata !== f || ocredit_vch !== 1'b1) begin
            bad++; $display("FAIL proto_fwd got=%b/%h/%h exp=1/%h/1", ovalid, odata, ocredit_vch, f);
        end
        total++; if (oerr !== 1'b1) begin bad++; $display("FAIL proto_oerr got=%b exp=1", oerr); end
        apply_reset();
    endtask

    task automatic test_reset_mid();
        logic [DATA_BITS-1:0] h, b, b2, ht;
        int stray = 0;
        h  = mk(FLIT_HEAD, 'h91); b = mk(FLIT_BODY, 'h92);
        b2 = mk(FLIT_BODY, 'h93); ht = mk(FLIT_HEADTAIL, 'h94);
        iready = 1'b1;
        ivalid = 1'b1; ivch = 1'b1; idata = h;
        step();
        idata = b;
        step();
        ivalid = 1'b0;
        step();
        total++; if (ovalid !== 1'b1 || odata !== b) begin
            bad++; $display("FAIL rstmid_body got=%b/%h exp=1/%h", ovalid, odata, b);
        end
        iready = 1'b0;
        ivalid = 1'b1; ivch = 1'b1; idata = b2;
        step();
        ivalid = 1'b0;
        rst_   = 1'b0;
        step();
        rst_ = 1'b1;
        total++;
        if (odata !== '0 || ovalid !== 1'b0 || ocredit !== 1'b0 || ocredit_vch !== '0 || oerr !== 1'b0) begin
            bad++; $display("FAIL rstmid_zero got=%h/%b/%b/%h/%b exp=0/0/0/0/0",
                            odata, ovalid, ocredit, ocredit_vch, oerr);
        end
        iready = 1'b1;
        ivalid = 1'b1; ivch = 1'b0; idata = ht;
        step();
        ivalid = 1'b0;
        step();
        total++; if (ovalid !== 1'b1 || odata !== ht || ocredit_vch !== 1'b0) begin
            bad++; $display("FAIL rstmid_new got=%b/%h/%h exp=1/%h/0", ovalid, odata, ocredit_vch, ht);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            if (ovalid) stray++;
        end
        total++; if (stray !== 0) begin bad++; $display("FAIL rstmid_discard got=%0d stray flits exp=0", stray); end
        total++; if (oerr !== 1'b0) begin bad++; $display("FAIL rstmid_oerr got=%b exp=0", oerr); end
    endtask

`ifdef PE_EJECT_STATS_EN
    task automatic test_stats();
        apply_reset();
        iready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ivalid = 1'b1; ivch = 1'b0; idata = mk(FLIT_HEADTAIL, 'hA0 + i);
            step();
        end
        ivalid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        total++; if (opkt_cnt !== 16'd3) begin bad++; $display("FAIL stats_cnt got=%0d exp=3", opkt_cnt); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ = 1'b1; ivalid = 1'b0; iready = 1'b0; ivch = '0; idata = '0;
        test_reset();
        test_single();
        test_interleave();
        test_stall();
        test_full_pop();
        test_overflow();
        test_proto_err();
        test_reset_mid();
`ifdef PE_EJECT_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_eject.md
Name: pe_eject

Overview:
- Sits between the router's local ejection port and pe_fsm, on the PE side of the node.
- Buffers incoming flits per virtual channel (2 VCs) and returns one credit per flit drained.
- Delivers flits to the PE one whole packet at a time: head to tail from a single VC, never interleaved. pe_fsm's tail-based packet counting depends on this.
- Stalls delivery while the PE is not ready to accept flits, for example while it is in SEND.

Parameters:
- DEPTH, 4, flit slots per VC FIFO; power of two, minimum 2.
- NVCH, 2, number of VCs; must equal 2^(`VCHW+1).

Ports:
- clk  input  1  system clock.
- rst_  input  1  synchronous active-low reset; compared against `Enable_.
- idata  input  `DATAW+1  flit from router ejection port.
- ivalid  input  1  idata/ivch valid this cycle.
- ivch  input  `VCHW+1  VC of the incoming flit.
- iready  input  1  PE can accept a flit this cycle; tied to (pe_fsm state != SEND).
- odata  output  `DATAW+1  flit to pe_fsm idata.
- ovalid  output  1  odata valid; drives pe_fsm ivalid.
- ocredit  output  1  one-cycle credit pulse to the router.
- ocredit_vch  output  `VCHW+1  VC the credit belongs to.
- oerr  output  1  sticky overflow flag.

Behaviour:
- Reset values: odata=0, ovalid=0, ocredit=0, ocredit_vch=0, oerr=0, all FIFOs empty, unlocked, rr pointer=0.
  - Reset mid-packet discards all buffered flits and the lock. No credits are issued for discarded flits; the router resets on the same rst_.
- Push:
  - When ivalid=1, the flit is written to FIFO[ivch].
  - If FIFO[ivch] is full and is not popped in the same cycle, the flit is dropped and oerr is set to 1. oerr clears only on reset.
  - A full FIFO that is popped in the same cycle accepts the push.
- Flit type comes from idata[`TYPE_MSB:`TYPE_LSB].
  - HEAD and HEADTAIL open a packet.
  - TAIL and HEADTAIL close a packet.
- Arbitration FSM, states UNLOCKED and LOCKED(v):
  - UNLOCKED: if iready=1, pick a non-empty VC round-robin starting from rr. Pop its head flit and register it.
    - If the popped flit is HEAD (not HEADTAIL), go to LOCKED(v).
    - After a pop, rr is set to v+1 (mod NVCH).
  - LOCKED(v): pop only FIFO[v], only when it is non-empty and iready=1.
    - Popping a TAIL returns to UNLOCKED.
    - Other VCs are never served in this state, even when FIFO[v] is empty.
  - A non-head flit at the front of a FIFO while UNLOCKED is a protocol error: pop and forward it anyway, and set oerr.
- Output timing:
  - The pop happens in cycle N. odata and ovalid are registered and valid in cycle N+1.
  - ovalid=0 in any cycle following a cycle without a pop.
  - Maximum throughput is 1 flit/cycle.
  - Minimum latency from ivalid to ovalid is 2 cycles: write in cycle N, pop in cycle N+1, output in cycle N+2.
- Credit: ocredit=1 and ocredit_vch=v are registered in the same cycle as the ovalid they correspond to.
- iready is sampled in the pop cycle only. A flit already registered is presented even if iready falls; pe_fsm tolerates this.

Optional Feature:
- Macro: PE_EJECT_STATS_EN.
- Defined: adds output opkt_cnt [15:0].
  - Counts forwarded TAIL/HEADTAIL flits.
  - Wraps 16'hFFFF -> 0; reset 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- define.v: `PE_EJ_DEPTH default, plus `TYPE_HEAD/`TYPE_TAIL/`TYPE_HEADTAIL encodings and `VCHW/`DATAW (existing).
- Sub-module pe_eject_vcfifo:
  - Single-VC synchronous FIFO with DEPTH parameter, push/pop/full/empty/head-data outputs.
  - Instantiated NVCH times via generate.
- The arbiter, lock FSM and output registers stay in pe_eject.

Test Plan:
- Single flit: 1 HEADTAIL flit on VC0 with iready=1 -> ovalid=1 exactly 2 cycles after ivalid, with odata equal to the input; ocredit=1 with ocredit_vch=0 in the same cycle; unlocked afterward.
- Interleave blocking: 4-flit packet on VC1 and 4-flit packet on VC0, injected alternately starting VC1 -> output is all 4 VC1 flits (H,B,B,T), then all 4 VC0 flits; exactly 8 credits, 4 per VC.
- Stall: iready=0 for 10 cycles while 3 flits are buffered on VC0 -> no ovalid and no credits; after iready=1, 3 consecutive ovalid cycles.
- Overflow: with DEPTH=4 and iready=0, 5 flits on VC0 -> 5th flit dropped and oerr=1 from the next cycle; after draining, only 4 flits out.
- Full with simultaneous pop: FIFO full, iready=1, new push on the same VC in the same cycle -> accepted, oerr stays 0.
- Reset mid-packet: rst_=0 for 1 cycle after HEAD+BODY delivered on VC1 -> all outputs 0 the next cycle; a new HEADTAIL on VC0 is delivered normally.
- With PE_EJECT_STATS_EN: 3 packets forwarded -> opkt_cnt=3.
